// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared instruction-set types for the issue queue and its helpers
//    PC_set    : decoded instruction record passed decoder -> queue -> Issue_EXE
//    INST_ALU  : inst_type encoding of a plain ALU operation
//    DEPTH_DEF : default queue depth
//    strip     : drops the o_valid flag before an entry is stored
package issue_queue_pkg;
   localparam int DEPTH_DEF = 8;
   localparam logic [9:0] INST_ALU = 10'h001;
   typedef struct packed {
      logic        o_valid;
      logic [31:0] PC;
      logic [9:0]  inst_type;
      logic        rf_we;
      logic [4:0]  rf_rd;
      logic [4:0]  rf_raddr1;
      logic [4:0]  rf_raddr2;
   } PC_set;
   function automatic PC_set strip(PC_set s);
      strip = s;
      strip.o_valid = 1'b0;
   endfunction
endpackage

// File: rtl/issue_pair_check.sv
// issue_pair_check: decides whether two adjacent entries may issue together
//    older   in  PC_set  entry at head
//    younger in  PC_set  entry at head+1
//    pair_ok out 1       no RAW from older to younger and at least one is ALU
module issue_pair_check
   import issue_queue_pkg::*;
(
   input  PC_set older,
   input  PC_set younger,
   output logic  pair_ok
);
   logic raw;
   assign raw = older.rf_we && older.rf_rd != 5'd0 &&
                (older.rf_rd == younger.rf_raddr1 || older.rf_rd == younger.rf_raddr2);
   // one ALU op in the pair lets Issue_EXE swap lanes freely
   assign pair_ok = !raw && (older.inst_type == INST_ALU || younger.inst_type == INST_ALU);
endmodule

// File: rtl/issue_queue.sv
// issue_queue: dual-push, dual-pop circular instruction queue feeding Issue_EXE
//    clk, rstn     clock, asynchronous active-low reset
//    d_set1/2      in   decoded instructions (older/younger), o_valid = present
//    flush_BR      in   mispredict flush, drops everything, wins over all else
//    stall_DCache  in   back-end stall, holds issue
//    o_ready       out  at least two free slots
//    o_set1/2      out  issue candidates (older/younger)
//    o_count       out  occupied entries
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  PC_set            d_set1,
   input  PC_set            d_set2,
   input  logic             flush_BR,
   input  logic             stall_DCache,
   output logic             o_ready,
   output PC_set            o_set1,
   output PC_set            o_set2,
   output logic [PTR_W:0]   o_count
);
   PC_set            mem [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   count;
   logic             pair_ok, live, accept;
   logic [1:0]       push_n, pop_n;
   PC_set            e0, e1;

   assign e0 = mem[head];
   assign e1 = mem[head + PTR_W'(1)];

   issue_pair_check u_pair (
      .older   (e0),
      .younger (e1),
      .pair_ok (pair_ok)
   );

   assign o_count = count;
   assign o_ready = count <= (PTR_W+1)'(DEPTH - 2);
   assign live    = !stall_DCache && !flush_BR;
   assign accept  = o_ready && !flush_BR;
   assign push_n  = accept ? {1'b0, d_set1.o_valid} + {1'b0, d_set2.o_valid} : 2'd0;
   assign pop_n   = {1'b0, o_set1.o_valid} + {1'b0, o_set2.o_valid};

   always_comb begin
      o_set1 = e0;
      o_set1.o_valid = count != '0 && live;
      o_set2 = e1;
      o_set2.o_valid = count > (PTR_W+1)'(1) && pair_ok && live;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush_BR) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop_n);
         tail  <= tail + PTR_W'(push_n);
         count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
         if (accept && d_set1.o_valid) mem[tail] <= strip(d_set1);
         // a lone d_set2 lands at tail so storage stays compact
         if (accept && d_set2.o_valid) mem[tail + PTR_W'(d_set1.o_valid)] <= strip(d_set2);
      end
   end

   a_count_max: assert property (@(posedge clk) disable iff (!rstn) count <= (PTR_W+1)'(DEPTH));
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed self-checking bench for issue_queue
module tb_issue_queue;
   import issue_queue_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   PC_set      d1 = '0, d2 = '0;
   logic       flush = 1'b0, stall = 1'b0;
   logic       ready;
   PC_set      s1, s2;
   logic [3:0] count;
   int         tests = 0, fails = 0;
   int         mc, pops;
   logic [31:0] exp_pc, push_pc;

   issue_queue dut (
      .clk          (clk),
      .rstn         (rstn),
      .d_set1       (d1),
      .d_set2       (d2),
      .flush_BR     (flush),
      .stall_DCache (stall),
      .o_ready      (ready),
      .o_set1       (s1),
      .o_set2       (s2),
      .o_count      (count)
   );

   always #5 clk = ~clk;

   function automatic PC_set mk(logic [31:0] pc, logic [9:0] t, logic we,
                                logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
      mk = '{o_valid: 1'b1, PC: pc, inst_type: t, rf_we: we, rf_rd: rd, rf_raddr1: r1, rf_raddr2: r2};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset
      #12;
      chk("rst_ready", 32'(ready), 1);
      chk("rst_count", 32'(count), 0);
      chk("rst_v1", 32'(s1.o_valid), 0);
      chk("rst_v2", 32'(s2.o_valid), 0);
      cyc();
      rstn = 1'b1;
      cyc();
      // independent ALU pair issues together
      d1 = mk(32'h1C000000, INST_ALU, 1'b1, 5'd1, 5'd2, 5'd3);
      d2 = mk(32'h1C000004, INST_ALU, 1'b1, 5'd6, 5'd7, 5'd8);
      cyc();
      d1 = '0; d2 = '0; #1;
      chk("t1_count2", 32'(count), 2);
      chk("t1_pc1", s1.PC, 32'h1C000000);
      chk("t1_pc2", s2.PC, 32'h1C000004);
      chk("t1_v1", 32'(s1.o_valid), 1);
      chk("t1_v2", 32'(s2.o_valid), 1);
      cyc();
      chk("t1_count0", 32'(count), 0);
      // RAW: add r4<-r1,r2 ; sub r5<-r4,r3
      d1 = mk(32'h1C000008, INST_ALU, 1'b1, 5'd4, 5'd1, 5'd2);
      d2 = mk(32'h1C00000C, INST_ALU, 1'b1, 5'd5, 5'd4, 5'd3);
      cyc();
      d1 = '0; d2 = '0; #1;
      chk("raw_v1", 32'(s1.o_valid), 1);
      chk("raw_pc1", s1.PC, 32'h1C000008);
      chk("raw_v2", 32'(s2.o_valid), 0);
      cyc();
      chk("raw_count1", 32'(count), 1);
      chk("raw_pc_sub", s1.PC, 32'h1C00000C);
      chk("raw_sub_v1", 32'(s1.o_valid), 1);
      chk("raw_sub_v2", 32'(s2.o_valid), 0);
      cyc();
      // two loads: no ALU in pair, single issue twice
      d1 = mk(32'h1C000010, 10'h002, 1'b1, 5'd9, 5'd1, 5'd2);
      d2 = mk(32'h1C000014, 10'h002, 1'b1, 5'd10, 5'd3, 5'd4);
      cyc();
      d1 = '0; d2 = '0; #1;
      chk("ld_v2a", 32'(s2.o_valid), 0);
      chk("ld_pc1a", s1.PC, 32'h1C000010);
      cyc();
      chk("ld_count1", 32'(count), 1);
      chk("ld_pc1b", s1.PC, 32'h1C000014);
      chk("ld_v2b", 32'(s2.o_valid), 0);
      cyc();
      chk("ld_count0", 32'(count), 0);
      // fill to 7 under stall (head sits at index 6 now)
      stall = 1'b1;
      for (int k = 0; k < 6; k += 2) begin
         d1 = mk(32'h10000000 + 32'(4 * k), INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
         d2 = mk(32'h10000004 + 32'(4 * k), INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
         cyc();
      end
      d1 = '0; d2 = '0; #1;
      chk("fill_count6", 32'(count), 6);
      chk("fill_ready6", 32'(ready), 1);
      d1 = mk(32'h10000018, INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
      cyc();
      chk("fill_count7", 32'(count), 7);
      chk("fill_ready7", 32'(ready), 0);
      d1 = mk(32'h1000001C, INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
      d2 = mk(32'h10000020, INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
      cyc();
      chk("full_hold7", 32'(count), 7);
      d1 = '0; d2 = '0; stall = 1'b0; #1;
      chk("full_pc1", s1.PC, 32'h10000000);
      chk("full_pc2", s2.PC, 32'h10000004);
      chk("full_v2", 32'(s2.o_valid), 1);
      cyc();
      chk("drain_count5", 32'(count), 5);
      chk("drain_ready", 32'(ready), 1);
      // flush with simultaneous push at count 5
      flush = 1'b1;
      d1 = mk(32'h30000000, INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
      d2 = mk(32'h30000004, INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      chk("fl_v1", 32'(s1.o_valid), 0);
      chk("fl_v2", 32'(s2.o_valid), 0);
      cyc();
      flush = 1'b0; d1 = '0; d2 = '0; #1;
      chk("fl_count", 32'(count), 0);
      chk("fl_ready", 32'(ready), 1);
      chk("fl_after_v1", 32'(s1.o_valid), 0);
      // streaming with a one-entry offset so a pair spans indices 7 -> 0
      mc = 0;
      exp_pc = 32'h20000000;
      push_pc = 32'h20000000;
      for (int it = 0; it < 10; it++) begin
         d1 = mk(push_pc, INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
         d2 = (it == 0) ? PC_set'('0) : mk(push_pc + 32'd4, INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
         #1;
         chk("wr_count", 32'(count), 32'(mc));
         chk("wr_v1", 32'(s1.o_valid), 32'(mc >= 1));
         chk("wr_v2", 32'(s2.o_valid), 32'(mc >= 2));
         if (mc >= 1) chk("wr_pc1", s1.PC, exp_pc);
         if (mc >= 2) chk("wr_pc2", s2.PC, exp_pc + 32'd4);
         cyc();
         pops = (mc >= 2) ? 2 : mc;
         exp_pc += 32'(4 * pops);
         mc = mc + ((it == 0) ? 1 : 2) - pops;
         push_pc += (it == 0) ? 32'd4 : 32'd8;
      end
      // stall while pushing: count +2 per cycle, head fixed
      stall = 1'b1;
      for (int it = 0; it < 3; it++) begin
         d1 = mk(push_pc, INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
         d2 = mk(push_pc + 32'd4, INST_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
         push_pc += 32'd8;
         #1;
         chk("st_v1", 32'(s1.o_valid), 0);
         cyc();
         chk("st_count", 32'(count), 32'(mc + 2 * (it + 1)));
         chk("st_head_pc", s1.PC, exp_pc);
      end
      d1 = '0; d2 = '0; #1;
      chk("st_ready_full", 32'(ready), 0);
      stall = 1'b0; #1;
      chk("un_v1", 32'(s1.o_valid), 1);
      chk("un_pc1", s1.PC, exp_pc);
      chk("un_pc2", s2.PC, exp_pc + 32'd4);
      cyc();
      chk("un_count6", 32'(count), 6);
      // asynchronous reset mid-operation
      #2 rstn = 1'b0;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_v1", 32'(s1.o_valid), 0);
      chk("arst_ready", 32'(ready), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Dual-push, dual-pop circular instruction queue between the decoder and Issue_EXE.
- Each cycle it accepts 0–2 decoded PC_set entries from the decoder. Each cycle it presents 0–2 head entries to Issue_EXE as i_set1/i_set2.
- Pairing logic decides dual or single issue.
- The presented entries' rf_raddr1/rf_raddr2 drive the regfile read ports combinationally. Issue_EXE latches the resulting rdata.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥4.
- PTR_W, $clog2(DEPTH), head/tail pointer width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- d_set1  in  PC_set  older decoded instruction; d_set1.o_valid = present
- d_set2  in  PC_set  younger decoded instruction; d_set2.o_valid = present
- flush_BR  in  1  branch-mispredict flush
- stall_DCache  in  1  back-end stall; hold issue
- o_ready  out  1  ≥2 free slots; decoder may push this cycle
- o_set1  out  PC_set  older issue candidate, to Issue_EXE i_set1
- o_set2  out  PC_set  younger issue candidate, to Issue_EXE i_set2
- o_count  out  PTR_W+1  occupied entries

Behaviour:
- Interface: one clock (clk); reset rstn is asynchronous, active-low.
- Reset: head=0, tail=0, count=0. Storage o_valid bits cleared. Consequences: o_ready=1, o_count=0, o_set1.o_valid=0, o_set2.o_valid=0. Other o_set fields are don't-care but driven from storage, which resets to 0.
- Storage: DEPTH × PC_set registers. The o_valid field is not stored; validity comes from count.
- o_ready is combinational: (DEPTH − count) ≥ 2. Accept pushes only when o_ready=1. With o_ready=0, decoder inputs are ignored, and the decoder is responsible for holding them.
- Push:
  - push_n = d_set1.o_valid + d_set2.o_valid.
  - If only d_set2 is valid, it is written at tail, so storage is compacted.
  - Order is preserved: d_set1 goes before d_set2. tail += push_n, modulo DEPTH.
- Output (combinational from storage):
  - o_set1 = entry[head], o_valid = (count≥1) & ~stall_DCache & ~flush_BR.
  - o_set2 = entry[head+1], o_valid = dual & ~stall_DCache & ~flush_BR.
- dual is asserted when all of these hold:
  - count≥2;
  - no RAW hazard: not (entry[head].rf_we, entry[head].rf_rd≠0, and rf_rd equals entry[head+1].rf_raddr1 or rf_raddr2);
  - at least one of the two entries has inst_type==10'h001 (ALU). This keeps the Issue_EXE lane swap legal.
- Pop: pop_n = o_set1.o_valid + o_set2.o_valid. head += pop_n, modulo DEPTH.
- Count: count_next = count + push_n − pop_n, evaluated in the same cycle. This covers simultaneous push and pop, including push into a queue being drained from full−2.
- stall_DCache=1: pop_n=0 and head holds. Push still proceeds if o_ready.
- flush_BR=1 (priority over everything): head=tail=count=0 on the next edge. Pushes in the same cycle are discarded. o_set*.o_valid=0 in the flush cycle.
- Wrap-around: pointers wrap naturally at DEPTH. head+1 is computed modulo DEPTH, so a pair spanning index DEPTH−1→0 issues normally.
- Empty: count=0, no valid outputs. Single entry: only o_set1 valid.
- Full: count=DEPTH−1 or DEPTH gives o_ready=0. count never exceeds DEPTH; an assertion checks this.
- Reset mid-operation: all in-flight entries are dropped immediately and asynchronously.

Decomposition:
- PC_set struct, the inst_type encodings (ALU = 10'h001) and DEPTH default live in the Public_Info package.
- Sub-module issue_pair_check: combinational RAW/type check producing dual from two PC_set inputs. Reused later for forwarding logic.

Test Plan:
- Reset, then push two ALU ops at PC 0x1C000000/0x1C000004 with no dependency. Next cycle: o_set1.PC=0x1C000000, o_set2.PC=0x1C000004, both valid; count 2→0.
- Push add r4←r1,r2 then sub r5←r4,r3 → only o_set1 valid in cycle 1. sub issues alone as o_set1 in cycle 2.
- Push two load ops (inst_type≠10'h001) → single issue on two consecutive cycles.
- Fill to count=7 (DEPTH=8): o_ready=0, and a further push with valid inputs leaves count at 7. Then pop 2 → o_ready=1.
- Run 20 push/pop cycles so head wraps from 7 to 0 with a pair at indices 7,0 → both issue in PC order.
- With count=5, assert flush_BR together with a 2-entry push → next cycle count=0, o_ready=1, no outputs valid. With stall_DCache held 3 cycles and pushes continuing, count rises by 2 per cycle and head is unchanged.
